// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry adder split into STAGES chunks,
// one chunk per clock, with valid/ready flow control on both sides.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid, in_ready  operand handshake (in_ready = !stall)
//   a, b, cin           operands and carry-in
//   out_valid, out_ready result handshake
//   sum, carry, overflow result, unsigned carry-out, signed overflow
//
// Build option: define PIPELINED_ADDER_SAT_EN to saturate sum on
// signed overflow; carry and overflow still report the raw values.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int C = WIDTH / STAGES;

   logic             stall;
   logic [WIDTH-1:0] raw;
   logic             msb_a;
   logic             msb_b;

   // The whole pipe freezes as one unit, bubbles included.
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * C;
      localparam int HI = LO + C;
      localparam int UP = WIDTH - HI;

      logic          v_d;
      logic          v_q;
      logic [C-1:0]  xa;
      logic [C-1:0]  xb;
      logic          ci;
      logic [C:0]    s;
      logic [HI-1:0] r_d;
      logic [HI-1:0] r_q;
      logic          c_q;
      logic          am_d;
      logic          bm_d;
      logic          am_q;
      logic          bm_q;

      if (k == 0) begin : g_src
         assign v_d  = in_valid;
         assign xa   = a[C-1:0];
         assign xb   = b[C-1:0];
         assign ci   = cin;
         assign am_d = a[WIDTH-1];
         assign bm_d = b[WIDTH-1];
         assign r_d  = s[C-1:0];
      end else begin : g_src
         assign v_d  = g_st[k-1].v_q;
         assign xa   = g_st[k-1].g_op.ua[C-1:0];
         assign xb   = g_st[k-1].g_op.ub[C-1:0];
         assign ci   = g_st[k-1].c_q;
         assign am_d = g_st[k-1].am_q;
         assign bm_d = g_st[k-1].bm_q;
         assign r_d  = {s[C-1:0], g_st[k-1].r_q};
      end

      // One C-bit ripple per stage; s[C] is this chunk's carry-out.
      assign s = {1'b0, xa} + {1'b0, xb} + {{C{1'b0}}, ci};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q  <= 1'b0;
            r_q  <= '0;
            c_q  <= 1'b0;
            am_q <= 1'b0;
            bm_q <= 1'b0;
         end else if (!stall) begin
            v_q  <= v_d;
            r_q  <= r_d;
            c_q  <= s[C];
            am_q <= am_d;
            bm_q <= bm_d;
         end
      end

      // Operand bits still waiting for their chunk; absent in the
      // last stage, which has nothing left to add.
      if (UP > 0) begin : g_op
         logic [UP-1:0] ua_d;
         logic [UP-1:0] ub_d;
         logic [UP-1:0] ua;
         logic [UP-1:0] ub;

         if (k == 0) begin : g_ld
            assign ua_d = a[WIDTH-1:C];
            assign ub_d = b[WIDTH-1:C];
         end else begin : g_ld
            assign ua_d = g_st[k-1].g_op.ua[WIDTH-LO-1:C];
            assign ub_d = g_st[k-1].g_op.ub[WIDTH-LO-1:C];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ua <= '0;
               ub <= '0;
            end else if (!stall) begin
               ua <= ua_d;
               ub <= ub_d;
            end
         end
      end
   end

   assign out_valid = g_st[STAGES-1].v_q;
   assign raw       = g_st[STAGES-1].r_q;
   assign carry     = g_st[STAGES-1].c_q;
   assign msb_a     = g_st[STAGES-1].am_q;
   assign msb_b     = g_st[STAGES-1].bm_q;

   // Like-signed operands producing an opposite-signed result.
   assign overflow  = (msb_a == msb_b) && (raw[WIDTH-1] != msb_a);

`ifdef PIPELINED_ADDER_SAT_EN
   // Clamp toward the operands' sign: max positive or min negative.
   assign sum = overflow ? {msb_a, {(WIDTH-1){!msb_a}}} : raw;
`else
   assign sum = raw;
`endif

endmodule
